// File: rtl/acc_pkg.sv
// Shared constants for the adder-result block accumulator.
package acc_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ACC_W  = 40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W accumulator adder.
// With ACC_SATURATE_EN defined, a carry-out clamps the result to all ones.
module acc_add_sat
   import acc_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   logic [ACC_W:0] full;

   always_comb begin
      full = {1'b0, acc} + {1'b0, addend};
      ovf  = full[ACC_W];
`ifdef ACC_SATURATE_EN
      sum  = ovf ? '1 : full[ACC_W-1:0];
`else
      sum  = full[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/acc_block_32.sv
// Sums BLOCK_LEN adder results ({cout,sum}) and hands out one total per block.
// Optional ACC_SATURATE_EN selects saturating instead of wrapping accumulation.
module acc_block_32
   import acc_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int BLOCK_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_sum,
   input  logic              in_cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_ovf,
   output logic              busy
);

   localparam int CNT_W = $clog2(BLOCK_LEN + 1);

   state_t             state;
   state_t             state_nx;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   count;
   logic               ovf;
   logic [ACC_W-1:0]   add_sum;
   logic               add_ovf;
   logic               accept;
   logic               last;

   assign in_ready = (state != ST_HOLD);
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign last     = (count == CNT_W'(BLOCK_LEN - 1));

   acc_add_sat #(
      .ACC_W (ACC_W)
   ) u_add (
      .acc    (acc),
      .addend (ACC_W'({in_cout, in_sum})),
      .sum    (add_sum),
      .ovf    (add_ovf)
   );

   always_comb begin
      state_nx = state;
      if (clr) begin
         state_nx = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE, ST_ACCUM: if (accept) state_nx = last ? ST_HOLD : ST_ACCUM;
            ST_HOLD:           if (out_ready) state_nx = ST_IDLE;
            default:           state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // clr outranks everything; the drain and accept paths never overlap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else if (clr) begin
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else if (accept) begin
         acc   <= add_sum;
         count <= count + CNT_W'(1);
         ovf   <= ovf | add_ovf;
         if (last) begin
            out_data  <= add_sum;
            out_ovf   <= ovf | add_ovf;
            out_valid <= 1'b1;
         end
      end else if (state == ST_HOLD && out_ready) begin
         out_valid <= 1'b0;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_block_32.sv
// Scoreboard bench for acc_block_32: default, narrow-wrap and short-block instances.
module tb_acc_block_32;

   typedef struct {
      logic [39:0] data;
      logic        ovf;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;

   logic a_valid = 0, a_ready, a_cout = 0, a_ov, a_or = 0, a_ovf, a_busy;
   logic [31:0] a_sum = '0;
   logic [39:0] a_data;

   logic w_valid = 0, w_ready, w_cout = 0, w_ov, w_or = 0, w_ovf, w_busy;
   logic [31:0] w_sum = '0;
   logic [33:0] w_data;

   logic g_valid = 0, g_ready, g_cout = 0, g_ov, g_or = 0, g_ovf, g_busy;
   logic [31:0] g_sum = '0;
   logic [39:0] g_data;

   always #5 clk = ~clk;

   acc_block_32 dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(a_valid), .in_ready(a_ready), .in_sum(a_sum), .in_cout(a_cout),
      .out_valid(a_ov), .out_ready(a_or), .out_data(a_data), .out_ovf(a_ovf),
      .busy(a_busy)
   );

   acc_block_32 #(.ACC_W(34), .BLOCK_LEN(4)) dut_w (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(w_valid), .in_ready(w_ready), .in_sum(w_sum), .in_cout(w_cout),
      .out_valid(w_ov), .out_ready(w_or), .out_data(w_data), .out_ovf(w_ovf),
      .busy(w_busy)
   );

   acc_block_32 #(.BLOCK_LEN(3)) dut_g (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(g_valid), .in_ready(g_ready), .in_sum(g_sum), .in_cout(g_cout),
      .out_valid(g_ov), .out_ready(g_or), .out_data(g_data), .out_ovf(g_ovf),
      .busy(g_busy)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      step;
      checks++;
      if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", a_ov); end
      checks++;
      if (a_data !== 40'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", a_data); end
      checks++;
      if (a_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got=%b exp=0", a_ovf); end
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
      rst = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", a_ready); end
   endtask

   task automatic test_basic;
      logic [39:0] m;
      exp_t e;
      m = '0;
      for (int i = 0; i < 16; i++) m = m + 40'({1'b1, 32'h9FC66D58});
      q.push_back('{m, 1'b0});
      a_or = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a_valid = 1'b1; a_sum = 32'h9FC66D58; a_cout = 1'b1;
         if (i == 15) begin
            checks++;
            if (a_ov !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", a_ov); end
         end
         step;
      end
      a_valid = 1'b0;
      checks++;
      if (a_ov !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", a_ov); end
      e = q.pop_front();
      checks++;
      if (a_data !== e.data) begin errors++; $display("FAIL basic_data got=%h exp=%h", a_data, e.data); end
      checks++;
      if (a_ovf !== e.ovf) begin errors++; $display("FAIL basic_ovf got=%b exp=%b", a_ovf, e.ovf); end
      a_or = 1'b1; step; a_or = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [39:0] m;
      exp_t e;
      m = '0;
      for (int i = 0; i < 16; i++) m = m + 40'({1'b1, 32'h9FC66D59});
      q.push_back('{m, 1'b0});
      for (int i = 0; i < 16; i++) begin
         a_valid = 1'b1; a_sum = 32'h9FC66D59; a_cout = 1'b1;
         step;
      end
      e = q.pop_front();
      checks++;
      if (a_ov !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", a_ov); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (a_data !== e.data) begin errors++; $display("FAIL bp_data_stable got=%h exp=%h", a_data, e.data); end
         checks++;
         if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", a_ready); end
         step;
      end
      a_valid = 1'b0;
      a_or = 1'b1; step; a_or = 1'b0;
      checks++;
      if (a_ov !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got=%b exp=0", a_ov); end
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready got=%b exp=1", a_ready); end
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_drain_busy got=%b exp=0", a_busy); end
   endtask

   task automatic test_wrap;
      logic [33:0] m;
      logic [34:0] full;
      logic mo;
      exp_t e;
      m = '0; mo = 1'b0;
      for (int i = 0; i < 4; i++) begin
         full = {1'b0, m} + 35'({1'b1, 32'hFFFFFFFF});
         if (full[34]) mo = 1'b1;
`ifdef ACC_SATURATE_EN
         m = full[34] ? 34'h3FFFFFFFF : full[33:0];
         if (m == 34'h3FFFFFFFF) m = 34'h3FFFFFFFF;
`else
         m = full[33:0];
`endif
      end
`ifdef ACC_SATURATE_EN
      m = mo ? 34'h3FFFFFFFF : m;
`endif
      q.push_back('{40'(m), mo});
      for (int i = 0; i < 4; i++) begin
         w_valid = 1'b1; w_sum = 32'hFFFFFFFF; w_cout = 1'b1;
         step;
         if (i == 1) begin
            checks++;
            if (dut_w.ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf_early got=%b exp=0", dut_w.ovf); end
         end
         if (i == 2) begin
            checks++;
            if (dut_w.ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf_third got=%b exp=1", dut_w.ovf); end
         end
      end
      w_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (w_ov !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", w_ov); end
      checks++;
      if (40'(w_data) !== e.data) begin errors++; $display("FAIL wrap_data got=%h exp=%h", w_data, e.data); end
      checks++;
      if (w_ovf !== e.ovf) begin errors++; $display("FAIL wrap_out_ovf got=%b exp=%b", w_ovf, e.ovf); end
      w_or = 1'b1; step; w_or = 1'b0;
   endtask

   task automatic test_clr;
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         a_valid = 1'b1; a_sum = 32'd1; a_cout = 1'b0;
         step;
      end
      clr = 1'b1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready got=%b exp=1", a_ready); end
      step;
      clr = 1'b0; a_valid = 1'b0;
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", a_busy); end
      checks++;
      if (dut.acc !== 40'h0) begin errors++; $display("FAIL clr_acc got=%h exp=0", dut.acc); end
      q.push_back('{40'd16, 1'b0});
      for (int i = 0; i < 16; i++) begin
         a_valid = 1'b1; a_sum = 32'd1; a_cout = 1'b0;
         step;
      end
      a_valid = 1'b0;
      for (int k = 0; k < 5 && a_ov !== 1'b1; k++) step;
      e = q.pop_front();
      checks++;
      if (a_ov !== 1'b1) begin
         errors++; $display("FAIL clr_timeout got=%b exp=1", a_ov);
      end else if (a_data !== e.data) begin
         errors++; $display("FAIL clr_data got=%h exp=%h", a_data, e.data);
      end
      a_or = 1'b1; step; a_or = 1'b0;
   endtask

   task automatic test_rst_async;
      for (int i = 0; i < 16; i++) begin
         a_valid = 1'b1; a_sum = 32'd1; a_cout = 1'b0;
         step;
      end
      a_valid = 1'b0;
      checks++;
      if (a_ov !== 1'b1) begin errors++; $display("FAIL arst_hold got=%b exp=1", a_ov); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (a_ov !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", a_ov); end
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", a_busy); end
      checks++;
      if (a_data !== 40'h0) begin errors++; $display("FAIL arst_data got=%h exp=0", a_data); end
      step;
      rst = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", a_ready); end
   endtask

   task automatic test_gapped;
      logic [31:0] vals [3];
      exp_t e;
      vals[0] = 32'd5; vals[1] = 32'd7; vals[2] = 32'd9;
      q.push_back('{40'd21, 1'b0});
      for (int i = 0; i < 3; i++) begin
         g_valid = 1'b0;
         repeat ($urandom_range(1, 4)) step;
         checks++;
         if (g_ov !== 1'b0) begin errors++; $display("FAIL gap_early idx=%0d got=%b exp=0", i, g_ov); end
         g_valid = 1'b1; g_sum = vals[i]; g_cout = 1'b0;
         step;
      end
      g_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (g_ov !== 1'b1) begin errors++; $display("FAIL gap_valid got=%b exp=1", g_ov); end
      checks++;
      if (g_data !== e.data) begin errors++; $display("FAIL gap_data got=%h exp=%h", g_data, e.data); end
      g_or = 1'b1; step; g_or = 1'b0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_wrap;
      test_clr;
      test_rst_async;
      test_gapped;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
